// File: rtl/whack_scorer.sv
// Whack-a-mole judge: syncs/edge-detects buttons, scores each light window, tracks lives and game over.
// Latency: button rise to registered hit/miss is 4 clk edges; no backpressure (inputs sampled every cycle).
module whack_scorer #(
   parameter int SCORE_W    = 8,
   parameter int LIVES_INIT = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [8:0]         lights,
   input  logic [3:0]         position,
   input  logic [8:0]         buttons,
   output logic [SCORE_W-1:0] score,
   output logic [2:0]         lives,
   output logic               hit,
   output logic               miss,
   output logic               playing,
   output logic               game_over
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ON,
      S_ARMED,
      S_DONE,
      S_OVER
   } state_t;

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [2:0]         LIVES_LD  = 3'(LIVES_INIT);

   logic [8:0]         sync1_q, sync2_q, sync3_q, press_q;
   state_t             state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [2:0]         lives_q, lives_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;
   logic               win, sel, correct, lose;

   // Press is registered so a press appears one cycle after edge N+2 of the button rise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
         press_q <= '0;
      end else begin
         sync1_q <= buttons;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         press_q <= sync2_q & ~sync3_q;
      end
   end

   assign win     = |lights;
   assign sel     = |press_q;
   assign correct = (position <= 4'd8) && (press_q == (9'd1 << position));

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      lives_d = lives_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      lose    = 1'b0;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               score_d = '0;
               lives_d = LIVES_LD;
               state_d = S_WAIT_ON;
            end
         end
         S_WAIT_ON: begin
            if (win) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (!win) begin
               lose    = 1'b1;
               state_d = S_WAIT_ON;
            end else if (sel) begin
               if (correct) begin
                  hit_d = 1'b1;
                  if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
               end else begin
                  lose = 1'b1;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!win) state_d = S_WAIT_ON;
         end
         default: state_d = S_IDLE;
      endcase
      // Losing the last life overrides whichever branch was taken.
      if (lose) begin
         miss_d  = 1'b1;
         lives_d = lives_q - 3'd1;
         if (lives_q == 3'd1) state_d = S_OVER;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         score_q <= '0;
         lives_q <= '0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         lives_q <= lives_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

   assign score     = score_q;
   assign lives     = lives_q;
   assign hit       = hit_q;
   assign miss      = miss_q;
   assign playing   = (state_q == S_WAIT_ON) || (state_q == S_ARMED) || (state_q == S_DONE);
   assign game_over = (state_q == S_OVER);

endmodule
